// File: rtl/frame18_pkg.sv
// Shared definitions for the 18-bit / 128-word frame format (generator and deframer).
package frame18_pkg;

  localparam int W       = 18;
  localparam int N_MARK  = 3;
  localparam int N_DATA  = 93;
  localparam int N_PAD   = 31;
  localparam int GAP_MAX = 64;

  localparam logic [W-1:0] MARK_WORD     = 18'h0FFFF;
  localparam logic [6:0]   IDX_DATA0     = 7'd3;
  localparam logic [6:0]   IDX_CTRL      = 7'(IDX_DATA0 + N_DATA);
  localparam logic [6:0]   IDX_DATA_LAST = IDX_CTRL - 7'd1;
  localparam logic [1:0]   MARK_LAST     = 2'(N_MARK - 1);
  localparam logic [4:0]   PAD_LAST      = 5'(N_PAD - 1);

  typedef enum logic [2:0] {
    HUNT,
    MARK,
    DATA,
    CTRL,
    PAD
  } state_e;

  // Odd parity over the full word: a good word XORs to 1.
  function automatic logic parity_ok(input logic [W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/frame18_gap_timer.sv
// Counts idle cycles while enabled; strobes timeout on the GAP_MAX-th consecutive idle cycle.
module frame18_gap_timer #(
  parameter int GAP_MAX = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW = $clog2(GAP_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of idle cycles already seen, so the current idle cycle is cnt_q+1.
  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(GAP_MAX - 1)) begin
      timeout = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/frame18_w97_deframer.sv
// Receive-side deframer: locks on three marker words, delivers data/ctrl words and checks the pad tail.
module frame18_w97_deframer
  import frame18_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_word,
  input  logic          in_valid,
  output logic [15:0]   dout,
  output logic [6:0]    dout_idx,
  output logic          dout_valid,
  output logic [15:0]   ctrl_word,
  output logic          ctrl_valid,
  output logic          par_err,
  output logic          fmt_err,
  output logic          locked,
  output logic          frame_done,
  output logic [7:0]    err_cnt
);

  state_e      state_q, state_d;
  logic [1:0]  mark_cnt_q, mark_cnt_d;
  logic [6:0]  idx_q, idx_d;
  logic [4:0]  pad_cnt_q, pad_cnt_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] dout_q, dout_d;
  logic [6:0]  dout_idx_q, dout_idx_d;
  logic        dout_valid_q, dout_valid_d;
  logic [15:0] ctrl_word_q, ctrl_word_d;
  logic        ctrl_valid_q, ctrl_valid_d;
  logic        par_err_q, par_err_d;
  logic        fmt_err_q, fmt_err_d;
  logic        locked_q, locked_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic gap_timeout;
  logic gap_enable;
  logic is_mark;
  logic par_ok;
  logic abort;
  logic finish;

  assign is_mark    = (in_word == MARK_WORD);
  assign par_ok     = parity_ok(in_word);
  assign gap_enable = (state_q == DATA) || (state_q == CTRL) || (state_q == PAD);

  frame18_gap_timer #(.GAP_MAX(GAP_MAX)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (in_valid),
    .enable  (gap_enable),
    .timeout (gap_timeout)
  );

  always_comb begin
    state_d      = state_q;
    mark_cnt_d   = mark_cnt_q;
    idx_d        = idx_q;
    pad_cnt_d    = pad_cnt_q;
    frame_err_d  = frame_err_q;
    dout_d       = dout_q;
    dout_idx_d   = dout_idx_q;
    dout_valid_d = 1'b0;
    ctrl_word_d  = ctrl_word_q;
    ctrl_valid_d = 1'b0;
    par_err_d    = 1'b0;
    fmt_err_d    = 1'b0;
    locked_d     = locked_q;
    frame_done_d = 1'b0;
    err_cnt_d    = err_cnt_q;
    abort        = 1'b0;
    finish       = 1'b0;

    if (gap_timeout) begin
      fmt_err_d = 1'b1;
      abort     = 1'b1;
    end else if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (is_mark) begin
            state_d    = MARK;
            mark_cnt_d = 2'd1;
          end
        end
        MARK: begin
          if (!is_mark) begin
            state_d    = HUNT;
            mark_cnt_d = '0;
          end else if (mark_cnt_q == MARK_LAST) begin
            state_d     = DATA;
            mark_cnt_d  = '0;
            locked_d    = 1'b1;
            idx_d       = IDX_DATA0;
            frame_err_d = 1'b0;
          end else begin
            mark_cnt_d = mark_cnt_q + 2'd1;
          end
        end
        DATA: begin
          if (in_word[16]) begin
            dout_d       = in_word[15:0];
            dout_idx_d   = idx_q;
            dout_valid_d = 1'b1;
            par_err_d    = !par_ok;
            if (idx_q == IDX_DATA_LAST) state_d = CTRL;
            else                        idx_d   = idx_q + 7'd1;
          end else begin
            fmt_err_d = 1'b1;
            abort     = 1'b1;
          end
        end
        CTRL: begin
          // A mis-tagged control word is flagged but the frame still runs into its pad tail.
          if (!in_word[16]) begin
            ctrl_word_d  = in_word[15:0];
            ctrl_valid_d = 1'b1;
            par_err_d    = !par_ok;
          end else begin
            fmt_err_d = 1'b1;
          end
          state_d   = PAD;
          pad_cnt_d = '0;
        end
        PAD: begin
          if (in_word != '0) fmt_err_d = 1'b1;
          if (pad_cnt_q == PAD_LAST) finish    = 1'b1;
          else                       pad_cnt_d = pad_cnt_q + 5'd1;
        end
        default: state_d = HUNT;
      endcase
    end

    frame_err_d = frame_err_d | par_err_d | fmt_err_d;

    if (abort || finish) begin
      state_d    = HUNT;
      locked_d   = 1'b0;
      mark_cnt_d = '0;
    end
    frame_done_d = finish;

    // Aborts always count; completed frames count only if they carried an error.
    if ((abort || (finish && frame_err_d)) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      mark_cnt_q   <= '0;
      idx_q        <= '0;
      pad_cnt_q    <= '0;
      frame_err_q  <= 1'b0;
      dout_q       <= '0;
      dout_idx_q   <= '0;
      dout_valid_q <= 1'b0;
      ctrl_word_q  <= '0;
      ctrl_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      fmt_err_q    <= 1'b0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      mark_cnt_q   <= mark_cnt_d;
      idx_q        <= idx_d;
      pad_cnt_q    <= pad_cnt_d;
      frame_err_q  <= frame_err_d;
      dout_q       <= dout_d;
      dout_idx_q   <= dout_idx_d;
      dout_valid_q <= dout_valid_d;
      ctrl_word_q  <= ctrl_word_d;
      ctrl_valid_q <= ctrl_valid_d;
      par_err_q    <= par_err_d;
      fmt_err_q    <= fmt_err_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_idx   = dout_idx_q;
  assign dout_valid = dout_valid_q;
  assign ctrl_word  = ctrl_word_q;
  assign ctrl_valid = ctrl_valid_q;
  assign par_err    = par_err_q;
  assign fmt_err    = fmt_err_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_frame18_w97_deframer.sv
// Bench for frame18_w97_deframer: scenario table, hand sequences and random frames vs a stream-level model.
module tb_frame18_w97_deframer;

  localparam logic [17:0] MARK_W = 18'h0FFFF;

  localparam int K_CLEAN   = 0;
  localparam int K_PAR     = 1;
  localparam int K_TAG     = 2;
  localparam int K_GAP     = 3;
  localparam int K_PAD     = 4;
  localparam int K_CTRLTAG = 5;
  localparam int K_CTRLPAR = 6;
  localparam int K_HGAP    = 7;
  localparam int K_GAP63   = 8;
  localparam int K_RST     = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] in_word;
  logic        in_valid;
  logic [15:0] dout;
  logic [6:0]  dout_idx;
  logic        dout_valid;
  logic [15:0] ctrl_word;
  logic        ctrl_valid;
  logic        par_err;
  logic        fmt_err;
  logic        locked;
  logic        frame_done;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  frame18_w97_deframer dut (
    .clk        (clk),
    .rst        (rst),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .dout       (dout),
    .dout_idx   (dout_idx),
    .dout_valid (dout_valid),
    .ctrl_word  (ctrl_word),
    .ctrl_valid (ctrl_valid),
    .par_err    (par_err),
    .fmt_err    (fmt_err),
    .locked     (locked),
    .frame_done (frame_done),
    .err_cnt    (err_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Stream-level reference: position within the 128-word frame, or -1 while hunting.
  int          m_run, m_pos, m_idle;
  bit          m_ferr, m_locked;
  bit          m_dv, m_cv, m_pe, m_fe, m_done;
  logic [15:0] m_dout, m_ctrl;
  logic [6:0]  m_idx;
  logic [7:0]  m_ec;

  int s_dv, s_cv, s_pe, s_fe, s_done;

  typedef struct {
    string name;
    int    n_mark;
    int    kind;
    int    err_idx;
    int    e_dv;
    int    e_cv;
    int    e_pe;
    int    e_fe;
    int    e_done;
    int    e_ec;
  } scen_t;

  scen_t tbl[11];

  function automatic logic [17:0] mkWord(input logic tag, input logic [15:0] p);
    return {~^{tag, p}, tag, p};
  endfunction

  task automatic modelAbort();
    m_pos    = -1;
    m_locked = 1'b0;
    m_idle   = 0;
    m_run    = 0;
    if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
  endtask

  task automatic modelStep(input bit r, input bit v, input logic [17:0] w);
    m_dv = 0; m_cv = 0; m_pe = 0; m_fe = 0; m_done = 0;
    if (r) begin
      m_run = 0; m_pos = -1; m_idle = 0; m_ferr = 0; m_locked = 0;
      m_dout = '0; m_ctrl = '0; m_idx = '0; m_ec = '0;
      return;
    end
    if (m_pos < 0) begin
      if (v) begin
        if (w == MARK_W) m_run++;
        else             m_run = 0;
        if (m_run == 3) begin
          m_run = 0; m_pos = 3; m_locked = 1; m_ferr = 0; m_idle = 0;
        end
      end
    end else if (!v) begin
      m_idle++;
      if (m_idle == 64) begin
        m_fe = 1;
        modelAbort();
      end
    end else begin
      m_idle = 0;
      if (m_pos <= 95) begin
        if (w[16]) begin
          m_dv = 1; m_idx = 7'(m_pos); m_dout = w[15:0]; m_pe = ~^w; m_pos++;
        end else begin
          m_fe = 1;
          modelAbort();
        end
      end else if (m_pos == 96) begin
        if (!w[16]) begin
          m_cv = 1; m_ctrl = w[15:0]; m_pe = ~^w;
        end else begin
          m_fe = 1;
        end
        m_pos++;
      end else begin
        if (w != '0) m_fe = 1;
        if (m_pos == 127) m_done = 1;
        else              m_pos++;
      end
      if (m_pe || m_fe) m_ferr = 1;
      if (m_done) begin
        if (m_ferr && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
        m_pos = -1; m_locked = 0; m_run = 0;
      end
    end
  endtask

  task automatic checkOutput(input string name);
    logic [52:0] act, exp;
    act = {dout, dout_idx, dout_valid, ctrl_word, ctrl_valid, par_err, fmt_err, locked, frame_done, err_cnt};
    exp = {m_dout, m_idx, m_dv, m_ctrl, m_cv, m_pe, m_fe, m_locked, m_done, m_ec};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s t=%0t {dout,idx,dv,ctrl,cv,pe,fe,lk,done,ec} actual=%h expected=%h",
               name, $time, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [17:0] w);
    rst      = r;
    in_valid = v;
    in_word  = w;
    @(posedge clk);
    modelStep(r, v, w);
    #1;
    s_dv   += int'(dout_valid);
    s_cv   += int'(ctrl_valid);
    s_pe   += int'(par_err);
    s_fe   += int'(fmt_err);
    s_done += int'(frame_done);
    checkOutput("cycle");
  endtask

  task automatic sendFrame(input int n_mark, input int kind, input int err_idx, input bit rnd);
    logic [17:0] w;
    logic [15:0] cw;
    cw = rnd ? 16'($urandom) : 16'h1234;
    if (kind == K_HGAP) repeat (64) applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < 128; i++) begin
      if (i < 3 && i >= n_mark) continue;
      if (kind == K_GAP   && i == err_idx) repeat (64) applyStimulus(1'b0, 1'b0, '0);
      if (kind == K_GAP63 && i == err_idx) repeat (63) applyStimulus(1'b0, 1'b0, '0);
      if (rnd && $urandom_range(0, 15) == 0) repeat ($urandom_range(1, 5)) applyStimulus(1'b0, 1'b0, '0);
      if (kind == K_RST && i == err_idx) begin
        applyStimulus(1'b1, 1'b0, '0);
        checkCount("reset_outputs_zero",
                   int'({dout, dout_idx, dout_valid, ctrl_word, ctrl_valid, par_err, fmt_err,
                         locked, frame_done, err_cnt} != '0), 0);
      end
      if (i < 3)       w = MARK_W;
      else if (i < 96) w = mkWord(1'b1, rnd ? 16'($urandom) : 16'(i));
      else if (i == 96) w = mkWord(1'b0, cw);
      else             w = '0;
      if (i == err_idx) begin
        case (kind)
          K_PAR, K_CTRLPAR: w[17] = ~w[17];
          K_TAG:            w = mkWord(1'b0, w[15:0]);
          K_PAD:            w = 18'h1;
          K_CTRLTAG:        w = mkWord(1'b1, cw);
          default:          ;
        endcase
      end
      applyStimulus(1'b0, 1'b1, w);
    end
  endtask

  initial begin
    int ec0;
    int kind, idx, nm;

    tbl[0]  = '{"clean",     3, K_CLEAN,    0, 93, 1, 0, 0, 1, 0};
    tbl[1]  = '{"par10",     3, K_PAR,     10, 93, 1, 1, 0, 1, 1};
    tbl[2]  = '{"two_marks", 2, K_CLEAN,    0,  0, 0, 0, 0, 0, 0};
    tbl[3]  = '{"tag50",     3, K_TAG,     50, 47, 0, 0, 1, 0, 1};
    tbl[4]  = '{"clean_b2b", 3, K_CLEAN,    0, 93, 1, 0, 0, 1, 0};
    tbl[5]  = '{"gap40",     3, K_GAP,     40, 37, 0, 0, 1, 0, 1};
    tbl[6]  = '{"hunt_gap",  3, K_HGAP,     0, 93, 1, 0, 0, 1, 0};
    tbl[7]  = '{"gap63",     3, K_GAP63,   70, 93, 1, 0, 0, 1, 0};
    tbl[8]  = '{"pad100",    3, K_PAD,    100, 93, 1, 0, 1, 1, 1};
    tbl[9]  = '{"ctrl_tag",  3, K_CTRLTAG, 96, 93, 0, 0, 1, 1, 1};
    tbl[10] = '{"ctrl_par",  3, K_CTRLPAR, 96, 93, 1, 1, 0, 1, 1};

    rst = 1'b1; in_valid = 1'b0; in_word = '0;
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);

    for (int t = 0; t < 11; t++) begin
      s_dv = 0; s_cv = 0; s_pe = 0; s_fe = 0; s_done = 0;
      ec0 = int'(err_cnt);
      sendFrame(tbl[t].n_mark, tbl[t].kind, tbl[t].err_idx, 1'b0);
      applyStimulus(1'b0, 1'b0, '0);
      checkCount({tbl[t].name, "_dout_valid"}, s_dv, tbl[t].e_dv);
      checkCount({tbl[t].name, "_ctrl_valid"}, s_cv, tbl[t].e_cv);
      checkCount({tbl[t].name, "_par_err"}, s_pe, tbl[t].e_pe);
      checkCount({tbl[t].name, "_fmt_err"}, s_fe, tbl[t].e_fe);
      checkCount({tbl[t].name, "_frame_done"}, s_done, tbl[t].e_done);
      checkCount({tbl[t].name, "_err_cnt_delta"}, int'(err_cnt) - ec0, tbl[t].e_ec);
    end

    // Reset in the middle of a frame, then a clean frame afterwards.
    s_dv = 0;
    sendFrame(3, K_RST, 60, 1'b0);
    checkCount("rst60_err_cnt", int'(err_cnt), 0);
    s_dv = 0; s_done = 0;
    sendFrame(3, K_CLEAN, 0, 1'b0);
    checkCount("post_rst_dout_valid", s_dv, 93);
    checkCount("post_rst_frame_done", s_done, 1);

    // Saturation: many short aborted frames.
    for (int n = 0; n < 260; n++) begin
      repeat (3) applyStimulus(1'b0, 1'b1, MARK_W);
      applyStimulus(1'b0, 1'b1, mkWord(1'b0, 16'(n)));
    end
    checkCount("err_cnt_saturated", int'(err_cnt), 255);
    applyStimulus(1'b1, 1'b0, '0);
    checkCount("err_cnt_after_rst", int'(err_cnt), 0);

    // Random frames with random error injection, gaps and noise between frames.
    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 6);
      nm   = ($urandom_range(0, 7) == 0) ? 2 : 3;
      case (kind)
        K_PAD:              idx = $urandom_range(97, 127);
        K_CTRLTAG, K_CTRLPAR: idx = 96;
        default:            idx = $urandom_range(3, 95);
      endcase
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 1'b1, 18'($urandom));
      sendFrame(nm, kind, idx, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
